fifo_rd_stream: RTL



---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/fifo_rd_stream_sat_cnt.sv | 32 +++
 rtl/fifo_rd_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream stage: skid-buffer
// occupancy encoding and default widths.
package fifo_rd_pkg;

  localparam int DSIZE_DEFAULT = 8;
  localparam int CSIZE_DEFAULT = 16;

  // The encoding is the occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/fifo_rd_stream_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
// Clear has priority, but a clear that coincides with an increment
// loads 1 so that the beat in the clearing cycle is not lost.
module sat_cnt
  import fifo_rd_pkg::*;
#(
  parameter int CSIZE = CSIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CSIZE-1:0] count
);

  // One extra bit; its carry out marks the all-ones value.
  logic [CSIZE:0] count_inc;

  assign count_inc = {1'b0, count} + {{CSIZE{1'b0}}, 1'b1};

  // Clear, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? {{(CSIZE-1){1'b0}}, 1'b1} : '0;
    end else if (inc && !count_inc[CSIZE]) begin
      count <= count_inc[CSIZE-1:0];
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops words from the FIFO read port and presents
// them as a valid/ready stream through a 2-entry skid buffer. rinc is a
// function of registered signals only, so m_ready never reaches the FIFO
// combinationally; the skid entry absorbs the word popped in the first
// cycle of backpressure.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int CSIZE = CSIZE_DEFAULT
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             clr_count,
  output logic [CSIZE-1:0] count
);

  buf_state_t       state;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic             push;
  logic             pop;

  // rrst_n gates rinc directly so no pop is requested while in reset.
  assign rinc    = rrst_n & ~rempty & (state != FULL);
  assign m_valid = (state != EMPTY);
  assign m_data  = head;
  assign push    = rinc;
  assign pop     = m_valid & m_ready;

  // Occupancy state and data movement; head is always the oldest word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state <= ONE;
            head  <= rdata;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state <= FULL;
            skid  <= rdata;
          end else if (!push && pop) begin
            state <= EMPTY;
          end else if (push && pop) begin
            head <= rdata;
          end
        end
        FULL: begin
          // rinc is held low here, so only a pop can move the state.
          if (pop) begin
            state <= ONE;
            head  <= skid;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_cnt #(
    .CSIZE(CSIZE)
  ) u_beat_cnt (
    .clk  (rclk),
    .rst_n(rrst_n),
    .clr  (clr_count),
    .inc  (pop),
    .count(count)
  );

endmodule
